output_drain: RTL and testbench
===============================

# output_drain

Streams the finished accumulation tile out of the output buffer after a layer pass, one element per beat, over a valid/ready handshake. It sits directly downstream of the output buffer. While draining, it freezes the buffer's `enable`. After the last beat it pulses the buffer's clear. Each element is right-shifted and saturated to activation width, producing the next layer's input stream.

## Interface
- `OUTPUT_CHANNEL`, default 4: channels in the tile.
- `OUTPUT_HEIGHT`, default 4: rows per channel.
- `OUTPUT_WIDTH`, default 4: columns per row.
- `OUT_BIN_LEN`, default 16: accumulator width, unsigned.
- `ACT_LEN`, default 8: output activation width, unsigned.
- `SHIFT`, default 2: requantization right shift, 0..`OUT_BIN_LEN`-1.

Ports:
- `clock` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low; 0 = reset.
- `start` input 1: one-cycle pulse; the tile in `output_vals` is final.
- `output_vals` input [`OUTPUT_CHANNEL`][`OUTPUT_HEIGHT`][`OUTPUT_WIDTH`] x `OUT_BIN_LEN`: the buffer contents.
- `out_ready` input 1: the consumer accepts a beat.
- `out_valid` output 1: `out_data` holds a beat.
- `out_data` output `ACT_LEN`: requantized element.
- `out_ch`, `out_row`, `out_col` output clog2 of each dimension: coordinates of the current beat.
- `out_last` output 1: the current beat is the final element.
- `busy` output 1: not IDLE. Drives the buffer's hold (`enable` gated low).
- `buf_clear` output 1: one-cycle pulse to the buffer's reset.
- `done` output 1: one-cycle pulse, same cycle as `buf_clear`.

## Operation
- FSM states: IDLE, DRAIN, CLEAR.
- IDLE -> DRAIN when `start`=1.
  - Load counters to (0,0,0).
  - Register the first beat.
- DRAIN: a beat transfers when `out_valid` and `out_ready` are both 1.
  - On transfer, advance in order: col fastest, then row, then channel.
  - Register the next element on the same edge.
- DRAIN -> CLEAR on transfer of the beat with `out_last`=1.
  - That beat is at (C-1, H-1, W-1).
- CLEAR: `buf_clear`=1 and `done`=1 for exactly one cycle, then -> IDLE.
- Requantization: `out_data` = min(`output_vals`[c][r][w] >> `SHIFT`, 2^`ACT_LEN`-1).
  - Logical shift; values are unsigned.
  - Saturate, never wrap.
- `start` is ignored in DRAIN and CLEAR. It is not queued.
- The upstream must not change `output_vals` while `busy`=1. The drain reads the live array at each load.
- Reset (`reset`=0), in any state including mid-drain:
  - Next state is IDLE; counters are 0.
  - `out_valid`, `out_last`, `busy`, `buf_clear`, `done` are 0.
  - `out_data` and the coordinates are 0.
  - No clear pulse is issued. The buffer keeps its contents.

## Timing
- `start` sampled at edge t: `out_valid`=1 with element (0,0,0) from cycle t+1.
- Throughput is 1 beat/cycle while `out_ready`=1.
- N = C·H·W.
- With `out_ready` held at 1:
  - Beats occupy cycles t+1..t+N.
  - `buf_clear` and `done` occur at t+N+1.
  - `busy` falls at t+N+2.
- Backpressure rule: while `out_valid`=1 and `out_ready`=0, these hold stable:
  - `out_data`, the coordinates, `out_last`, `out_valid`.
- `out_valid` never drops in DRAIN without a transfer.
- `busy`=1 from t+1 through the CLEAR cycle inclusive.
- A new `start` is accepted no earlier than the cycle after CLEAR.
- All outputs are registered. There is no combinational path from `out_ready` to `out_valid` or `out_data`.

## Test plan
- **Full-throughput drain.** C=H=W=2, `SHIFT`=2, `ACT_LEN`=8. Set element index k = 4k. Pulse `start` at t with `out_ready`=1.
  - `out_data` = 0..7 in cycles t+1..t+8.
  - Coordinates follow (c,r,w) raster order.
  - `out_last` is 1 only at t+8.
  - `buf_clear` and `done` pulse at t+9.
- **Saturation.** Element values 1024, 1020, 1016, 0xFFFF.
  - Required `out_data`: 255, 255, 254, 255.
  - No wrap to 0.
- **Backpressure.** `out_ready` pattern 1,0,0,1,0,1,…
  - Beat values and coordinates hold across every stall.
  - Exactly 8 transfers, in the same order as the full-throughput case.
  - `buf_clear` comes one cycle after the 8th transfer.
- **Spurious start.** Pulse `start` during DRAIN at beat 3, and again during the CLEAR cycle.
  - Neither pulse restarts or extends the drain.
  - A `start` one cycle after CLEAR begins a fresh drain from (0,0,0).
- **Reset mid-drain.** Drive `reset`=0 for one cycle after beat 3 transfers.
  - Next cycle: `out_valid`, `busy`, `out_last` are 0.
  - `buf_clear` never pulses.
  - A later `start` replays from element (0,0,0) with the original values.
- **Busy/hold.** Check `busy` across the drain.
  - It is 1 exactly from t+1 through the CLEAR cycle.
  - It is 0 in IDLE and during reset.

Source files
------------

// File: rtl/output_drain_if.sv
// Output-beat stream from output_drain to the next layer: valid/ready handshake
// carrying one requantized element plus its tile coordinates.
interface output_drain_if #(
  parameter int ACT_LEN = 8,
  parameter int CH_W    = 2,
  parameter int ROW_W   = 2,
  parameter int COL_W   = 2
) ();
  logic               out_valid;
  logic               out_ready;
  logic [ACT_LEN-1:0] out_data;
  logic [CH_W-1:0]    out_ch;
  logic [ROW_W-1:0]   out_row;
  logic [COL_W-1:0]   out_col;
  logic               out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/output_drain.sv
// Drains a finished accumulation tile one element per beat (col, row, channel
// raster order), requantizing each element, then pulses the buffer clear.
module output_drain #(
  parameter int OUTPUT_CHANNEL = 4,
  parameter int OUTPUT_HEIGHT  = 4,
  parameter int OUTPUT_WIDTH   = 4,
  parameter int OUT_BIN_LEN    = 16,
  parameter int ACT_LEN        = 8,
  parameter int SHIFT          = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OUTPUT_CHANNEL-1:0][OUTPUT_HEIGHT-1:0][OUTPUT_WIDTH-1:0][OUT_BIN_LEN-1:0] output_vals,
  output_drain_if.master       dn,
  output logic                 busy,
  output logic                 buf_clear,
  output logic                 done
);

  localparam int CH_W  = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1;
  localparam int ROW_W = (OUTPUT_HEIGHT  > 1) ? $clog2(OUTPUT_HEIGHT)  : 1;
  localparam int COL_W = (OUTPUT_WIDTH   > 1) ? $clog2(OUTPUT_WIDTH)   : 1;
  localparam int N     = OUTPUT_CHANNEL * OUTPUT_HEIGHT * OUTPUT_WIDTH;
  localparam int WW    = (OUT_BIN_LEN > ACT_LEN) ? OUT_BIN_LEN : ACT_LEN;

  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(OUTPUT_CHANNEL - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(OUTPUT_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(OUTPUT_WIDTH - 1);
  localparam logic [WW-1:0]    SAT_MAX = WW'({ACT_LEN{1'b1}});

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t             r_state, w_state_next;
  logic [CH_W-1:0]    r_ch,    w_ch;
  logic [ROW_W-1:0]   r_row,   w_row;
  logic [COL_W-1:0]   r_col,   w_col;
  logic [ACT_LEN-1:0] r_data,  w_data;
  logic               r_valid, w_valid;
  logic               r_last,  w_last;
  logic               r_busy;
  logic               r_clear;
  logic               w_xfer;

  // Logical right shift, then clamp to the activation range instead of wrapping.
  function automatic logic [ACT_LEN-1:0] requant(input logic [OUT_BIN_LEN-1:0] v);
    logic [WW-1:0] s;
    s = WW'(v) >> SHIFT;
    if (s > SAT_MAX) return '1;
    return s[ACT_LEN-1:0];
  endfunction

  assign w_xfer = r_valid && dn.out_ready;

  always_comb begin
    w_state_next = r_state;
    w_ch         = r_ch;
    w_row        = r_row;
    w_col        = r_col;
    w_data       = r_data;
    w_valid      = r_valid;
    w_last       = r_last;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = DRAIN;
          w_ch         = '0;
          w_row        = '0;
          w_col        = '0;
          w_data       = requant(output_vals[0][0][0]);
          w_valid      = 1'b1;
          w_last       = (N == 1);
        end
      end
      DRAIN: begin
        if (w_xfer) begin
          if (r_last) begin
            w_state_next = CLEAR;
            w_ch         = '0;
            w_row        = '0;
            w_col        = '0;
            w_data       = '0;
            w_valid      = 1'b0;
            w_last       = 1'b0;
          end else begin
            if (r_col == COL_MAX) begin
              w_col = '0;
              if (r_row == ROW_MAX) begin
                w_row = '0;
                w_ch  = r_ch + 1'b1;
              end else begin
                w_row = r_row + 1'b1;
              end
            end else begin
              w_col = r_col + 1'b1;
            end
            // Next element is fetched from the advanced coordinates on the same edge.
            w_data = requant(output_vals[w_ch][w_row][w_col]);
            w_last = (w_ch == CH_MAX) && (w_row == ROW_MAX) && (w_col == COL_MAX);
          end
        end
      end
      CLEAR: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ch    <= w_ch;
      r_row   <= w_row;
      r_col   <= w_col;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_last  <= w_last;
      r_busy  <= (w_state_next != IDLE);
      r_clear <= (w_state_next == CLEAR);
    end
  end

  assign dn.out_valid = r_valid;
  assign dn.out_data  = r_data;
  assign dn.out_ch    = r_ch;
  assign dn.out_row   = r_row;
  assign dn.out_col   = r_col;
  assign dn.out_last  = r_last;
  assign busy         = r_busy;
  assign buf_clear    = r_clear;
  assign done         = r_clear;

endmodule

// File: tb/tb_output_drain.sv
// Directed, table-driven bench for output_drain on a 2x2x2 tile with SHIFT=2.
module tb_output_drain;

  logic clock;
  logic reset;
  logic start;
  logic [1:0][1:0][1:0][15:0] vals;
  logic busy, buf_clear, done;

  output_drain_if #(.ACT_LEN(8), .CH_W(1), .ROW_W(1), .COL_W(1)) bus ();

  output_drain #(
    .OUTPUT_CHANNEL(2),
    .OUTPUT_HEIGHT (2),
    .OUTPUT_WIDTH  (2),
    .OUT_BIN_LEN   (16),
    .ACT_LEN       (8),
    .SHIFT         (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .output_vals(vals),
    .dn         (bus),
    .busy       (busy),
    .buf_clear  (buf_clear),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic       rdy;
    logic       valid;
    logic [7:0] data;
    logic [2:0] coord;
    logic       last;
    logic       busy;
    logic       clr;
  } vec_t;

  vec_t tbl[$];
  int checks;
  int failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_vals(input logic [15:0] v[8]);
    for (int k = 0; k < 8; k++) vals[k[2]][k[1]][k[0]] = v[k];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Row i describes the cycle i after the initial start edge: inputs driven and outputs expected.
  task automatic build(input logic [7:0] ev[8], input logic [31:0] pat,
                       input logic [31:0] stmask, input int nrows);
    int   mst;
    int   beat;
    vec_t v;
    tbl.delete();
    mst  = 1;
    beat = 0;
    for (int i = 0; i < nrows; i++) begin
      v.start = stmask[i];
      v.rdy   = pat[i];
      v.valid = (mst == 1);
      v.data  = (mst == 1) ? ev[beat] : 8'h00;
      v.coord = 3'(beat);
      v.last  = (mst == 1) && (beat == 7);
      v.busy  = (mst != 0);
      v.clr   = (mst == 2);
      tbl.push_back(v);
      case (mst)
        1: if (pat[i]) begin
             if (beat == 7) begin mst = 2; beat = 0; end
             else beat++;
           end
        2: mst = 0;
        default: if (stmask[i]) begin mst = 1; beat = 0; end
      endcase
    end
  endtask

  task automatic run_tbl(input string tag);
    int xf_act;
    int xf_exp;
    xf_act = 0;
    xf_exp = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      start        = tbl[i].start;
      bus.out_ready = tbl[i].rdy;
      chk($sformatf("%s[%0d].valid", tag, i), 32'(bus.out_valid), 32'(tbl[i].valid));
      chk($sformatf("%s[%0d].last", tag, i), 32'(bus.out_last), 32'(tbl[i].last));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("%s[%0d].buf_clear", tag, i), 32'(buf_clear), 32'(tbl[i].clr));
      chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(tbl[i].clr));
      if (tbl[i].valid) begin
        chk($sformatf("%s[%0d].data", tag, i), 32'(bus.out_data), 32'(tbl[i].data));
        chk($sformatf("%s[%0d].coord", tag, i),
            32'({bus.out_ch, bus.out_row, bus.out_col}), 32'(tbl[i].coord));
      end
      if (bus.out_valid && bus.out_ready) xf_act++;
      if (tbl[i].valid && tbl[i].rdy) xf_exp++;
      step();
    end
    start = 1'b0;
    chk($sformatf("%s.xfers", tag), 32'(xf_act), 32'(xf_exp));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".last"}, 32'(bus.out_last), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".buf_clear"}, 32'(buf_clear), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".data"}, 32'(bus.out_data), 32'd0);
    chk({tag, ".coord"}, 32'({bus.out_ch, bus.out_row, bus.out_col}), 32'd0);
  endtask

  logic [15:0] ramp[8];
  logic [15:0] satv[8];
  logic [7:0]  ramp_exp[8];
  logic [7:0]  sat_exp[8];
  logic [31:0] pat;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    start    = 1'b0;
    bus.out_ready = 1'b0;

    ramp     = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd16, 16'd20, 16'd24, 16'd28};
    ramp_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    satv     = '{16'd1024, 16'd1020, 16'd1016, 16'hFFFF, 16'd0, 16'd3, 16'd4, 16'd1023};
    sat_exp  = '{8'd255, 8'd255, 8'd254, 8'd255, 8'd0, 8'd0, 8'd1, 8'd255};
    set_vals(ramp);

    repeat (3) step();
    chk_quiet("reset");
    reset = 1'b1;
    step();
    chk_quiet("idle");

    // Full-throughput drain.
    build(ramp_exp, 32'hFFFF_FFFF, 32'h0, 10);
    pulse_start();
    run_tbl("full");

    // Saturation.
    set_vals(satv);
    build(sat_exp, 32'hFFFF_FFFF, 32'h0, 10);
    pulse_start();
    run_tbl("sat");

    // Backpressure: ready 1,0,0,1,0,1,0,0,1,1,0,1,0,1,1 then held high.
    set_vals(ramp);
    pat = 32'hFFFF_FFFF;
    pat[1] = 1'b0; pat[2] = 1'b0; pat[4] = 1'b0; pat[6] = 1'b0;
    pat[7] = 1'b0; pat[10] = 1'b0; pat[12] = 1'b0;
    build(ramp_exp, pat, 32'h0, 17);
    pulse_start();
    run_tbl("bp");

    // Spurious starts at beat 3 and in CLEAR are ignored; start right after CLEAR restarts.
    build(ramp_exp, 32'hFFFF_FFFF, 32'h0000_0308, 20);
    pulse_start();
    run_tbl("spur");

    // Reset mid-drain, after beat 3 transfers.
    bus.out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_pre[%0d].data", i), 32'(bus.out_data), 32'(ramp_exp[i]));
      step();
    end
    chk("rst_pre.beat4", 32'(bus.out_data), 32'd4);
    reset = 1'b0;
    step();
    chk_quiet("rst_mid");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_post[%0d].buf_clear", i), 32'(buf_clear), 32'd0);
      chk($sformatf("rst_post[%0d].busy", i), 32'(busy), 32'd0);
      step();
    end
    build(ramp_exp, 32'hFFFF_FFFF, 32'h0, 10);
    pulse_start();
    run_tbl("replay");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
